// File: rtl/nios_leds_out_pio_if.sv
// nios_leds_out_pio_if
//   Avalon-MM slave bus bundle for the LED output PIO.
//   Signals:
//     address    [1:0]  word address (0 data, 1 set, 2 clear, 3 blink mask)
//     chipselect        slave select
//     write_n           active-low write strobe
//     writedata  [31:0] write data
//     readdata   [31:0] registered read data, zero-extended
//   Modports:
//     master  drives address/chipselect/write_n/writedata, receives readdata
//     slave   receives address/chipselect/write_n/writedata, drives readdata
interface nios_leds_out_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_leds_out_pio.sv
// nios_leds_out_pio
//   Avalon-MM output PIO driving board LEDs. Holds a data register with
//   readback, supports write-1-to-set / write-1-to-clear updates, and a
//   per-bit blink engine: bits selected in the blink mask are forced off
//   during alternate half-periods of BLINK_DIV clock cycles.
//   Ports:
//     clk       system clock, rising edge
//     reset_n   asynchronous active-low reset
//     avs       Avalon-MM slave bus (nios_leds_out_pio_if.slave)
//     out_port  registered LED drive, DATA_WIDTH bits
module nios_leds_out_pio #(
    parameter int                    DATA_WIDTH  = 18,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    BLINK_DIV   = 25000000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    nios_leds_out_pio_if.slave    avs,
    output logic [DATA_WIDTH-1:0] out_port
);

    localparam int CNT_W = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_SET   = 2'd1;
    localparam logic [1:0] ADDR_CLR   = 2'd2;
    localparam logic [1:0] ADDR_BLINK = 2'd3;

    function automatic logic [31:0] zext(input logic [DATA_WIDTH-1:0] v);
        logic [31:0] r;
        r = '0;
        r[DATA_WIDTH-1:0] = v;
        return r;
    endfunction

    logic                  wr;
    logic [DATA_WIDTH-1:0] wd;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [DATA_WIDTH-1:0] blink_mask;
    logic [CNT_W-1:0]      blink_cnt;
    logic                  blink_phase;
    logic                  blink_wr;
    logic                  unused_wd;

    assign wr        = avs.chipselect & ~avs.write_n;
    assign wd        = avs.writedata[DATA_WIDTH-1:0];
    assign blink_wr  = wr && (avs.address == ADDR_BLINK);
    // Upper writedata bits are intentionally ignored.
    assign unused_wd = ^avs.writedata;

    // ---- Stage 0: register file updated by bus writes ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= RESET_VALUE;
        end else if (wr) begin
            case (avs.address)
                ADDR_DATA: data_reg <= wd;
                ADDR_SET:  data_reg <= data_reg | wd;
                ADDR_CLR:  data_reg <= data_reg & ~wd;
                default:   data_reg <= data_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_mask <= '0;
        end else if (blink_wr) begin
            blink_mask <= wd;
        end
    end

    // Blink prescaler. A mask write restarts the cadence and takes priority
    // over a wrap in the same cycle, so a freshly blinked LED always starts lit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_wr || (blink_mask == '0)) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == CNT_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + CNT_W'(1);
        end
    end

    // Read data samples the registers before any same-cycle write lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs.readdata <= '0;
        end else begin
            case (avs.address)
                ADDR_DATA:  avs.readdata <= zext(data_reg);
                ADDR_BLINK: avs.readdata <= zext(blink_mask);
                default:    avs.readdata <= '0;
            endcase
        end
    end

    // ---- Stage 1: LED drive register, lags the register file by one cycle ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= RESET_VALUE;
        end else begin
            out_port <= data_reg & ~(blink_mask & {DATA_WIDTH{blink_phase}});
        end
    end

endmodule
